// File: rtl/hs_seq_sink.sv
// hs_seq_sink: valid/ready stream receiver used as a synthesizable self-checking sink.
// It drives in_ready_o with a selectable backpressure pattern and checks that every
// accepted beat equals the previous accepted beat plus one, starting from START_VAL.
// Beats and mismatches are counted, and the run stops after num_beats_i beats (0 = unlimited).
//
// Optional feature: define HS_SINK_PROTO_CHECK_EN to add a valid/data stability monitor
// with a sticky proto_err_o output. Without the macro that port and its logic are absent.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start_i        1-cycle pulse that begins a run (ignored while busy)
//   mode_i         ready pattern: 0 always, 1 toggle, 2 LFSR, 3 ON/OFF duty
//   num_beats_i    beats per run, 0 = unlimited (sampled at start)
//   in_data_i      stream data
//   in_valid_i     stream valid
//   in_ready_o     stream ready (registered)
//   beat_cnt_o     beats accepted this run
//   err_cnt_o      sequence mismatches this run, saturating
//   err_o          sticky mismatch flag, cleared by start
//   done_o         high when the programmed beat count has been reached
//   busy_o         high while a run is in progress
//   proto_err_o    sticky protocol violation flag (HS_SINK_PROTO_CHECK_EN only)
module hs_seq_sink #(
    parameter int unsigned    DW        = 8,
    parameter int unsigned    CW        = 16,
    parameter logic [DW-1:0]  START_VAL = '0,
    parameter int unsigned    ON_CYC    = 3,
    parameter int unsigned    OFF_CYC   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [1:0]    mode_i,
    input  logic [CW-1:0] num_beats_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic [CW-1:0] beat_cnt_o,
    output logic [CW-1:0] err_cnt_o,
    output logic          err_o,
    output logic          done_o,
    output logic          busy_o
`ifdef HS_SINK_PROTO_CHECK_EN
    ,
    output logic          proto_err_o
`endif
);

    localparam int unsigned   PERIOD     = ON_CYC + OFF_CYC;
    localparam int unsigned   PW         = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] DUTY_LAST  = PW'(PERIOD - 1);
    localparam logic [PW-1:0] DUTY_ON    = PW'(ON_CYC);
    localparam logic [7:0]    LFSR_SEED  = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [CW-1:0]   num_q, num_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   errc_q, errc_d;
    logic            err_q, err_d;
    logic [DW-1:0]   exp_q, exp_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [PW-1:0]   duty_q, duty_d;
    logic            rdy_q, rdy_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            start_go_c;
    logic            accept_c;
    logic            term_c;
    logic [CW-1:0]   beat_inc_c;
    logic [7:0]      lfsr_nxt_c;
    logic [PW-1:0]   duty_nxt_c;

    // Shared decode used by both next-state and output logic
    assign start_go_c = start_i && (state_q != S_RUN);
    assign accept_c   = in_valid_i && rdy_q;
    assign beat_inc_c = beat_q + CW'(1);
    assign term_c     = accept_c && (num_q != '0) && (beat_inc_c == num_q);
    // Fibonacci LFSR, taps 8,6,5,4; the new bit enters at bit0
    assign lfsr_nxt_c = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign duty_nxt_c = (duty_q == DUTY_LAST) ? '0 : duty_q + PW'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (term_c)  state_d = S_DONE;
            S_DONE:  if (start_i) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        mode_d = mode_q;
        num_d  = num_q;
        beat_d = beat_q;
        errc_d = errc_q;
        err_d  = err_q;
        exp_d  = exp_q;
        lfsr_d = lfsr_q;
        duty_d = duty_q;
        rdy_d  = 1'b0;
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_RUN);

        if (start_go_c) begin
            mode_d = mode_i;
            num_d  = num_beats_i;
            beat_d = '0;
            errc_d = '0;
            err_d  = 1'b0;
            exp_d  = START_VAL;
            lfsr_d = LFSR_SEED;
            duty_d = '0;
        end else if (state_q == S_RUN) begin
            lfsr_d = lfsr_nxt_c;
            duty_d = duty_nxt_c;
            if (accept_c) begin
                beat_d = beat_inc_c;
                if (in_data_i != exp_q) begin
                    err_d = 1'b1;
                    if (errc_q != '1) errc_d = errc_q + CW'(1);
                end
                // Resync on the received value so a dropped beat costs one error
                exp_d = in_data_i + DW'(1);
            end
        end

        // Ready for the upcoming cycle; low whenever the next state is not RUN
        if (state_d == S_RUN) begin
            if (start_go_c) begin
                rdy_d = (mode_i == 2'd2) ? LFSR_SEED[0] : 1'b1;
            end else begin
                case (mode_q)
                    2'd0:    rdy_d = 1'b1;
                    2'd1:    rdy_d = ~rdy_q;
                    2'd2:    rdy_d = lfsr_nxt_c[0];
                    default: rdy_d = (duty_nxt_c < DUTY_ON);
                endcase
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            num_q  <= '0;
            beat_q <= '0;
            errc_q <= '0;
            err_q  <= 1'b0;
            exp_q  <= START_VAL;
            lfsr_q <= LFSR_SEED;
            duty_q <= '0;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            num_q  <= num_d;
            beat_q <= beat_d;
            errc_q <= errc_d;
            err_q  <= err_d;
            exp_q  <= exp_d;
            lfsr_q <= lfsr_d;
            duty_q <= duty_d;
            rdy_q  <= rdy_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign in_ready_o = rdy_q;
    assign beat_cnt_o = beat_q;
    assign err_cnt_o  = errc_q;
    assign err_o      = err_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;

`ifdef HS_SINK_PROTO_CHECK_EN
    logic          stall_q;
    logic [DW-1:0] pdata_q;
    logic          perr_q, perr_d;
    logic          viol_c;

    // A stalled beat must stay valid with stable data on the following cycle
    assign viol_c = stall_q && (!in_valid_i || (in_data_i != pdata_q));

    always_comb begin
        perr_d = perr_q | viol_c;
        if (start_go_c) perr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
            pdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            stall_q <= in_valid_i && !rdy_q;
            pdata_q <= in_data_i;
            perr_q  <= perr_d;
        end
    end

    assign proto_err_o = perr_q;
`endif

endmodule

// File: tb/tb_hs_seq_sink.sv
// tb_hs_seq_sink: table-driven runs with a beat scoreboard, plus hand-written sequences
// for ready patterns, data wrap with START_VAL=FE, mid-run reset and the protocol monitor.
module tb_hs_seq_sink;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;
    localparam logic [DW-1:0] SV0 = 8'h00;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [CW-1:0] num_beats;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] err_cnt;
    logic          err;
    logic          done;
    logic          busy;

    logic          f_start;
    logic [1:0]    f_mode;
    logic [CW-1:0] f_num;
    logic [DW-1:0] f_data;
    logic          f_valid;
    logic          f_ready;
    logic [CW-1:0] f_beat;
    logic [CW-1:0] f_errc;
    logic          f_err;
    logic          f_done;
    logic          f_busy;
`ifdef HS_SINK_PROTO_CHECK_EN
    logic          proto_err;
    logic          f_proto_err;
`endif

    hs_seq_sink #(.DW(DW), .CW(CW), .START_VAL(SV0), .ON_CYC(3), .OFF_CYC(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .num_beats_i(num_beats),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .beat_cnt_o(beat_cnt), .err_cnt_o(err_cnt), .err_o(err), .done_o(done), .busy_o(busy)
`ifdef HS_SINK_PROTO_CHECK_EN
        , .proto_err_o(proto_err)
`endif
    );

    hs_seq_sink #(.DW(DW), .CW(CW), .START_VAL(8'hFE), .ON_CYC(3), .OFF_CYC(2)) u_dut_fe (
        .clk(clk), .rst_n(rst_n), .start_i(f_start), .mode_i(f_mode), .num_beats_i(f_num),
        .in_data_i(f_data), .in_valid_i(f_valid), .in_ready_o(f_ready),
        .beat_cnt_o(f_beat), .err_cnt_o(f_errc), .err_o(f_err), .done_o(f_done), .busy_o(f_busy)
`ifdef HS_SINK_PROTO_CHECK_EN
        , .proto_err_o(f_proto_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [DW-1:0] data;
        bit            bad;
    } sb_t;

    sb_t           sb_q[$];
    logic [DW-1:0] sb_exp;
    int            exp_beats;
    int            exp_errs;

    typedef struct {
        logic [1:0] mode;
        int         num;
        int         skip;
        int         exp_beats;
        int         exp_errs;
        int         exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat_val(input int i, input int skip);
        int v;
        v = (skip >= 0 && i >= skip) ? i + 1 : i;
        return DW'(v);
    endfunction

    // Drive a beat and record what the sink should conclude when it accepts it
    task automatic present(input logic [DW-1:0] d);
        sb_t e;
        in_valid  = 1'b1;
        in_data   = d;
        e.data    = d;
        e.bad     = (d != sb_exp);
        sb_q.push_back(e);
        sb_exp    = d + DW'(1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_run(input logic [1:0] m, input int n, input bit with_data, input int skip);
        mode      = m;
        num_beats = CW'(n);
        start     = 1'b1;
        sb_q.delete();
        sb_exp    = SV0;
        exp_beats = 0;
        exp_errs  = 0;
        if (with_data) present(beat_val(0, skip));
        else in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
        check("start_beat_cnt", 32'(beat_cnt), 32'd0);
    endtask

    // Source side: hold each beat until accepted; scoreboard pops on every accept
    task automatic stream(input int n, input int skip, output int cyc);
        int   idx;
        logic acc;
        sb_t  e;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    exp_beats++;
                    if (e.bad) exp_errs++;
                end
                check("sb_beat_cnt", 32'(beat_cnt), 32'(exp_beats));
                check("sb_err_cnt", 32'(err_cnt), 32'(exp_errs));
                check("sb_err", 32'(err), 32'(exp_errs != 0));
                idx++;
                if (idx < n) present(beat_val(idx, skip));
                else in_valid = 1'b0;
            end
        end
        if (idx < n) check("stream_timeout", 32'(idx), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            cyc;
        logic [7:0]    l;
        logic [DW-1:0] fe_seq[4];
        int            w;

        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; start = 1'b0; mode = '0; num_beats = '0; in_data = '0; in_valid = 1'b0;
        f_start = 1'b0; f_mode = '0; f_num = '0; f_data = '0; f_valid = 1'b0;
        sb_exp = SV0; exp_beats = 0; exp_errs = 0;

        vecs[0] = '{2'd0, 10, -1, 10, 0, 10};
        vecs[1] = '{2'd1, 20, -1, 20, 0, 39};
        vecs[2] = '{2'd3,  5,  3,  5, 1,  7};
        vecs[3] = '{2'd2, 12, -1, 12, 0,  0};
        vecs[4] = '{2'd3,  8,  0,  8, 1, 12};
        vecs[5] = '{2'd1,  6,  2,  6, 1, 11};

        // Reset state
        #12;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven runs, each ending in DONE
        for (int v = 0; v < 6; v++) begin
            start_run(vecs[v].mode, vecs[v].num, 1'b1, vecs[v].skip);
            stream(vecs[v].num, vecs[v].skip, cyc);
            check("vec_done", 32'(done), 32'd1);
            check("vec_busy", 32'(busy), 32'd0);
            check("vec_beat_cnt", 32'(beat_cnt), 32'(vecs[v].exp_beats));
            check("vec_err_cnt", 32'(err_cnt), 32'(vecs[v].exp_errs));
            check("vec_err", 32'(err), 32'(vecs[v].exp_errs != 0));
            if (vecs[v].exp_cyc != 0) check("vec_cycles", 32'(cyc), 32'(vecs[v].exp_cyc));
`ifdef HS_SINK_PROTO_CHECK_EN
            check("vec_proto_err", 32'(proto_err), 32'd0);
`endif
            // No beat may be taken beyond num_beats
            in_valid = 1'b1;
            in_data  = 8'h77;
            repeat (3) begin
                @(posedge clk); #1;
                check("post_ready", 32'(in_ready), 32'd0);
            end
            check("post_beat_cnt", 32'(beat_cnt), 32'(vecs[v].exp_beats));
            check("post_done", 32'(done), 32'd1);
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end

        // Mode 3 duty pattern 3 high / 2 low
        do_reset();
        start_run(2'd3, 0, 1'b0, -1);
        for (int k = 0; k < 10; k++) begin
            check("duty_ready", 32'(in_ready), 32'((k % 5) < 3));
            @(posedge clk); #1;
        end

        // Mode 2 LFSR pattern
        do_reset();
        start_run(2'd2, 0, 1'b0, -1);
        l = 8'hA5;
        for (int k = 0; k < 12; k++) begin
            check("lfsr_ready", 32'(in_ready), 32'(l[0]));
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
            @(posedge clk); #1;
        end

        // Mid-run reset after 5 beats (one dropped), then a clean run
        do_reset();
        start_run(2'd2, 20, 1'b1, 2);
        stream(5, 2, cyc);
        check("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_run(2'd2, 8, 1'b1, -1);
        stream(8, -1, cyc);
        check("after_rst_done", 32'(done), 32'd1);
        check("after_rst_beat_cnt", 32'(beat_cnt), 32'd8);
        check("after_rst_err_cnt", 32'(err_cnt), 32'd0);

        // START_VAL=FE instance: wrap FE,FF,00,01 with no error, unlimited stays busy
        fe_seq[0] = 8'hFE; fe_seq[1] = 8'hFF; fe_seq[2] = 8'h00; fe_seq[3] = 8'h01;
        f_mode  = 2'd0;
        f_num   = '0;
        f_start = 1'b1;
        f_valid = 1'b1;
        f_data  = fe_seq[0];
        @(posedge clk); #1;
        f_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f_data = fe_seq[i];
            check("wrap_ready", 32'(f_ready), 32'd1);
            @(posedge clk); #1;
            check("wrap_beat_cnt", 32'(f_beat), 32'(i + 1));
            check("wrap_err_cnt", 32'(f_errc), 32'd0);
        end
        f_valid = 1'b0;
        @(posedge clk); #1;
        check("wrap_busy", 32'(f_busy), 32'd1);
        check("wrap_done", 32'(f_done), 32'd0);
        check("wrap_err", 32'(f_err), 32'd0);
        f_start = 1'b1;
        @(posedge clk); #1;
        f_start = 1'b0;
        check("run_start_ignored", 32'(f_beat), 32'd4);

`ifdef HS_SINK_PROTO_CHECK_EN
        // Valid dropped while stalled
        do_reset();
        start_run(2'd3, 0, 1'b0, -1);
        w = 0;
        while (in_ready != 1'b0 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check("proto_wait", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h33;
        @(posedge clk); #1;
        check("proto_before", 32'(proto_err), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("proto_err_set", 32'(proto_err), 32'd1);
        check("proto_err_cnt", 32'(err_cnt), 32'd0);
        check("proto_beat_cnt", 32'(beat_cnt), 32'd0);
`else
        w = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
